ipv4_checksum_verify_arbiter: RTL and testbench
===============================================

// Module: ipv4_checksum_verify_arbiter
// PURPOSE
//   Shares one ipv4_checksum_verify engine between N_PORTS header requesters.
//   Round-robin grant, at most one issue per cycle, in-order port-tag FIFO.
//   Each verify result is returned to its originating port as resp_valid/resp_ok/resp_port.
//   Sits between the per-port IPv4 parsers and the single verifier instance.
// PARAMETERS
//   N_PORTS        4  number of requesters (2..16)
//   MAX_INFLIGHT   4  max outstanding verifies; sets tag FIFO depth (power of 2)
//   STATS_W       32  per-port counter width (used only with the stats feature)
// PORTS
//   clk               in   1                  single clock
//   rst_n             in   1                  async assert, active-low reset
//   req_valid         in   N_PORTS            requester has a header
//   req_hdr           in   N_PORTS x ipv4_hdr_t  20-byte header fields per port
//   req_ready         out  N_PORTS            grant: header accepted this cycle
//   vfy_req           out  1                  issue strobe to the verifier
//   vfy_hdr           out  ipv4_hdr_t         fields to the verifier, registered
//   vfy_output_valid  in   1                  verifier result strobe
//   vfy_chksum_valid  in   1                  verifier pass/fail
//   resp_valid        out  1                  result strobe, registered
//   resp_ok           out  1                  1 = checksum correct
//   resp_port         out  $clog2(N_PORTS)    port the result belongs to
//   err_unexpected    out  1                  sticky: result arrived with FIFO empty
// BEHAVIOUR
//   - Reset: every output 0; rr pointer = 0; inflight = 0; FIFO empty; counters 0.
//   - Issue allowed when inflight < MAX_INFLIGHT.
//     Grant goes to the first asserted req_valid at or after rr_ptr (wraps N_PORTS-1 -> 0).
//   - req_ready is combinational: one-hot grant, 0 when no credit. Accept = valid & ready.
//   - On accept: next cycle vfy_req=1 and vfy_hdr=latched header; the port index is pushed
//     to the tag FIFO; rr_ptr = granted+1 mod N_PORTS. With no accept, vfy_req=0 and
//     vfy_hdr holds its value.
//   - On vfy_output_valid: pop the tag. Next cycle resp_valid=1,
//     resp_ok=vfy_chksum_valid, resp_port=tag.
//   - Latency: accept -> vfy_req is 1 cycle; vfy_output_valid -> resp_valid is 1 cycle.
//   - inflight counts +1 on issue and -1 on return; both in one cycle leaves it unchanged.
//   - Full (inflight==MAX_INFLIGHT): no grant, even if a return arrives that cycle
//     (no comb path from vfy_output_valid to req_ready).
//   - vfy_output_valid with FIFO empty: no pop, no resp; err_unexpected set until reset.
//   - Results are in issue order; the verifier must preserve order.
//   - No backpressure on resp: consumers sample resp_valid every cycle.
//   - Reset mid-operation flushes FIFO and credits. Results arriving after reset with an
//     empty FIFO raise err_unexpected; the integrator must reset both blocks together.
// CONFIGURATION
//   IPV4_CHKSUM_ARB_STATS_EN defined:
//     - adds per-port pass_cnt/fail_cnt (STATS_W, saturating), updated on resp_valid.
//     - adds outputs stats_pass/stats_fail (N_PORTS x STATS_W).
//     - adds input stats_clear (1-cycle pulse zeroes all counters; clear wins over increment).
//   Not defined: counters, ports and logic are absent; behaviour is otherwise identical.
// STRUCTURE
//   Package ipv4_chksum_pkg: ipv4_hdr_t packed struct (dscp, ecn, length, id, flags,
//   frag_off, ttl, protocol, hdr_chksum, src_ip, dst_ip); IPV4_HDR_BYTES=20.
//   Sub-module: ipv4_chksum_tag_fifo (sync FIFO of port tags, depth MAX_INFLIGHT, with
//   push/pop/full/empty). The round-robin grant stays inline.
// TESTING
//   Golden header: 4500 0073 0000 4000 4011 b861 c0a8 0001 c0a8 00c7 (checksum b861 valid).
//   1 Port 2 alone sends the golden header -> vfy_req 1 cycle later;
//     resp_valid with resp_ok=1, resp_port=2.
//   2 Golden header with hdr_chksum=b862 on port 0 -> resp_ok=0, resp_port=0.
//   3 All 4 ports valid continuously, rr_ptr=0 -> grants 0,1,2,3,0,...; each port gets
//     1 grant per 4 accepts.
//   4 Verifier latency 10, 6 back-to-back requests -> 4 issued, req_ready=0 until first
//     return; resp_port order matches issue order.
//   5 vfy_output_valid pulsed with nothing in flight -> no resp_valid;
//     err_unexpected=1 until rst_n low.
//   6 rst_n low with 3 in flight -> outputs 0, inflight 0; after release the first
//     request is granted on port 0 (STATS_EN: stats_clear same cycle as a pass -> count 0).

Source files
------------

// File: rtl/ipv4_checksum_verify_arbiter_pkg.sv
// Shared types for the IPv4 checksum verify arbiter slice.
// The header struct carries every 20-byte header field except version/IHL,
// which are fixed at 4/5 for the headers this path handles.
package ipv4_chksum_pkg;

  localparam int IPV4_HDR_BYTES = 20;

  typedef struct packed {
    logic [5:0]  dscp;
    logic [1:0]  ecn;
    logic [15:0] length;
    logic [15:0] id;
    logic [2:0]  flags;
    logic [12:0] frag_off;
    logic [7:0]  ttl;
    logic [7:0]  protocol;
    logic [15:0] hdr_chksum;
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
  } ipv4_hdr_t;

endpackage

// File: rtl/ipv4_checksum_verify_arbiter_if.sv
// Bundle of requester, verifier and response signals around the arbiter.
// slave  = the arbiter itself; master = parsers/verifier/consumers around it.
interface ipv4_checksum_verify_arbiter_if
  import ipv4_chksum_pkg::*;
#(
  parameter int N_PORTS = 4
);

  localparam int PW = $clog2(N_PORTS);

  logic [N_PORTS-1:0]            req_valid;
  ipv4_hdr_t [N_PORTS-1:0]       req_hdr;
  logic [N_PORTS-1:0]            req_ready;
  logic                          vfy_req;
  ipv4_hdr_t                     vfy_hdr;
  logic                          vfy_output_valid;
  logic                          vfy_chksum_valid;
  logic                          resp_valid;
  logic                          resp_ok;
  logic [PW-1:0]                 resp_port;

  modport slave (
    input  req_valid, req_hdr, vfy_output_valid, vfy_chksum_valid,
    output req_ready, vfy_req, vfy_hdr, resp_valid, resp_ok, resp_port
  );

  modport master (
    output req_valid, req_hdr, vfy_output_valid, vfy_chksum_valid,
    input  req_ready, vfy_req, vfy_hdr, resp_valid, resp_ok, resp_port
  );

endinterface

// File: rtl/ipv4_checksum_verify_arbiter_tag_fifo.sv
// In-order FIFO of port tags for verifies in flight. DEPTH must be a power
// of two >= 2; the extra pointer bit distinguishes full from empty.
module ipv4_chksum_tag_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

  // Tag storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  // Read/write pointers; reset empties the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/ipv4_checksum_verify_arbiter.sv
// Shares one checksum verifier between N_PORTS header requesters.
// Round-robin grant limited by MAX_INFLIGHT credits; the port tag of every
// issue is queued so in-order results are routed back to their port.
// Optional feature macro IPV4_CHKSUM_ARB_STATS_EN adds saturating per-port
// pass/fail counters with a synchronous clear.
module ipv4_checksum_verify_arbiter
  import ipv4_chksum_pkg::*;
#(
  parameter int N_PORTS      = 4,
  parameter int MAX_INFLIGHT = 4
`ifdef IPV4_CHKSUM_ARB_STATS_EN
  , parameter int STATS_W    = 32
`endif
) (
  input  logic clk,
  input  logic rst_n,
  ipv4_checksum_verify_arbiter_if.slave bus,
  output logic err_unexpected
`ifdef IPV4_CHKSUM_ARB_STATS_EN
  , input  logic                             stats_clear,
  output logic [N_PORTS-1:0][STATS_W-1:0]    stats_pass,
  output logic [N_PORTS-1:0][STATS_W-1:0]    stats_fail
`endif
);

  localparam int PW = $clog2(N_PORTS);
  localparam int CW = $clog2(MAX_INFLIGHT + 1);

  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] gnt_idx;
  logic          gnt_found;
  logic          credit;
  logic          accept;
  logic          pop;
  logic [CW-1:0] inflight;
  logic [PW-1:0] tag_rd;
  logic          tag_full;
  logic          tag_empty;

  // Credit depends only on registered state, so a same-cycle return never
  // opens a grant while full.
  assign credit = (inflight < CW'(MAX_INFLIGHT));
  assign accept = gnt_found & credit & ~tag_full;
  assign pop    = bus.vfy_output_valid & ~tag_empty;

  // Round-robin search: first valid requester at or after rr_ptr.
  always_comb begin
    int j;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    j         = 0;
    for (int i = 0; i < N_PORTS; i++) begin
      j = int'(rr_ptr) + i;
      if (j >= N_PORTS) j = j - N_PORTS;
      if (!gnt_found && bus.req_valid[j]) begin
        gnt_found = 1'b1;
        gnt_idx   = PW'(j);
      end
    end
  end

  // One-hot ready for the granted port only.
  always_comb begin
    bus.req_ready = '0;
    if (accept) bus.req_ready[gnt_idx] = 1'b1;
  end

  // Issue stage: strobe and header to the verifier, advance the pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.vfy_req <= 1'b0;
      bus.vfy_hdr <= '0;
      rr_ptr      <= '0;
    end else begin
      bus.vfy_req <= accept;
      if (accept) begin
        bus.vfy_hdr <= bus.req_hdr[gnt_idx];
        if (gnt_idx == PW'(N_PORTS - 1)) rr_ptr <= '0;
        else                             rr_ptr <= gnt_idx + PW'(1);
      end
    end
  end

  // Return stage: route each result to the tag at the FIFO head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.resp_valid <= 1'b0;
      bus.resp_ok    <= 1'b0;
      bus.resp_port  <= '0;
      err_unexpected <= 1'b0;
    end else begin
      bus.resp_valid <= pop;
      if (pop) begin
        bus.resp_ok   <= bus.vfy_chksum_valid;
        bus.resp_port <= tag_rd;
      end
      if (bus.vfy_output_valid && tag_empty) err_unexpected <= 1'b1;
    end
  end

  // Outstanding-verify credit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  ipv4_chksum_tag_fifo #(
    .W     (PW),
    .DEPTH (MAX_INFLIGHT)
  ) u_tag_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept),
    .pop   (pop),
    .wdata (gnt_idx),
    .rdata (tag_rd),
    .full  (tag_full),
    .empty (tag_empty)
  );

`ifdef IPV4_CHKSUM_ARB_STATS_EN
  // Saturating per-port pass/fail counters; clear takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stats_pass <= '0;
      stats_fail <= '0;
    end else if (stats_clear) begin
      stats_pass <= '0;
      stats_fail <= '0;
    end else if (bus.resp_valid) begin
      if (bus.resp_ok) begin
        if (stats_pass[bus.resp_port] != '1)
          stats_pass[bus.resp_port] <= stats_pass[bus.resp_port] + STATS_W'(1);
      end else begin
        if (stats_fail[bus.resp_port] != '1)
          stats_fail[bus.resp_port] <= stats_fail[bus.resp_port] + STATS_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_ipv4_checksum_verify_arbiter.sv
// Scoreboard bench for the checksum verify arbiter: requester queues per
// port, a fixed-latency in-order verifier model, and an expected-response
// queue filled at accept time.
module tb_ipv4_checksum_verify_arbiter;
  import ipv4_chksum_pkg::*;

  localparam int NP = 4;
  localparam int MI = 4;

  typedef struct {int port; bit ok;} exp_t;
  typedef struct {int due; bit ok;} vfy_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic err_unexpected;

  ipv4_checksum_verify_arbiter_if #(.N_PORTS(NP)) bus ();

`ifdef IPV4_CHKSUM_ARB_STATS_EN
  logic stats_clear = 1'b0;
  logic [NP-1:0][31:0] stats_pass;
  logic [NP-1:0][31:0] stats_fail;
`endif

  ipv4_checksum_verify_arbiter #(.N_PORTS(NP), .MAX_INFLIGHT(MI)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .err_unexpected (err_unexpected)
`ifdef IPV4_CHKSUM_ARB_STATS_EN
    , .stats_clear  (stats_clear),
    .stats_pass     (stats_pass),
    .stats_fail     (stats_fail)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int lat = 1;
  bit inj = 0;
  logic [NP-1:0] acc_mask = '0;

  ipv4_hdr_t port_q [NP][$];
  ipv4_hdr_t hdr_q [$];
  exp_t      exp_q [$];
  vfy_t      vq [$];
  int        acyc_q [$];
  int        grant_log [$];
  int        acc_log [$];
  int        ret_log [$];
  int        acc_cnt = 0;
  int        ret_cnt = 0;
  int        resp_cnt = 0;
  int        max_out = 0;
  int        last_port = -1;
  bit        last_ok = 0;

  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [15:0] csum(input ipv4_hdr_t h);
    logic [31:0] s;
    s = 32'({4'h4, 4'h5, h.dscp, h.ecn}) + 32'(h.length) + 32'(h.id)
      + 32'({h.flags, h.frag_off}) + 32'({h.ttl, h.protocol}) + 32'(h.hdr_chksum)
      + 32'(h.src_ip[31:16]) + 32'(h.src_ip[15:0])
      + 32'(h.dst_ip[31:16]) + 32'(h.dst_ip[15:0]);
    s = 32'(s[15:0]) + 32'(s[31:16]);
    s = 32'(s[15:0]) + 32'(s[31:16]);
    return s[15:0];
  endfunction

  function automatic bit hdr_ok(input ipv4_hdr_t h);
    return csum(h) == 16'hffff;
  endfunction

  function automatic ipv4_hdr_t golden();
    ipv4_hdr_t h;
    h.dscp = 6'd0; h.ecn = 2'd0; h.length = 16'h0073; h.id = 16'h0000;
    h.flags = 3'b010; h.frag_off = 13'd0; h.ttl = 8'h40; h.protocol = 8'h11;
    h.hdr_chksum = 16'hb861; h.src_ip = 32'hc0a80001; h.dst_ip = 32'hc0a800c7;
    return h;
  endfunction

  function automatic ipv4_hdr_t make_hdr(input int id, input bit good);
    ipv4_hdr_t h;
    h = golden();
    h.id = 16'(id);
    h.hdr_chksum = 16'h0;
    h.hdr_chksum = ~csum(h);
    if (!good) h.hdr_chksum = h.hdr_chksum ^ 16'h0001;
    return h;
  endfunction

  // Requester and verifier drivers, just after each rising edge.
  initial begin
    bus.req_valid = '0;
    bus.req_hdr = '0;
    bus.vfy_output_valid = 1'b0;
    bus.vfy_chksum_valid = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      for (int p = 0; p < NP; p++) begin
        if (acc_mask[p] && port_q[p].size() > 0) void'(port_q[p].pop_front());
        bus.req_valid[p] = (port_q[p].size() > 0);
        bus.req_hdr[p] = (port_q[p].size() > 0) ? port_q[p][0] : '0;
      end
      acc_mask = '0;
      bus.vfy_output_valid = 1'b0;
      bus.vfy_chksum_valid = 1'b0;
      if (inj) begin
        bus.vfy_output_valid = 1'b1;
        bus.vfy_chksum_valid = 1'b1;
        inj = 0;
      end else if (vq.size() > 0 && vq[0].due <= cyc) begin
        bus.vfy_output_valid = 1'b1;
        bus.vfy_chksum_valid = vq[0].ok;
        void'(vq.pop_front());
      end
    end
  end

  // Monitor and scoreboard on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int p = 0; p < NP; p++) begin
          if (bus.req_valid[p] && bus.req_ready[p]) begin
            acc_mask[p] = 1'b1;
            exp_q.push_back('{port: p, ok: hdr_ok(bus.req_hdr[p])});
            hdr_q.push_back(bus.req_hdr[p]);
            acyc_q.push_back(cyc);
            grant_log.push_back(p);
            acc_log.push_back(cyc);
            acc_cnt++;
          end
        end
        if (bus.vfy_req) begin
          if (hdr_q.size() == 0) chk("vfy_req_spurious", 1, 0);
          else begin
            chk("vfy_hdr", bus.vfy_hdr, hdr_q.pop_front());
            chk("issue_lat", cyc, acyc_q.pop_front() + 1);
            vq.push_back('{due: cyc + lat, ok: hdr_ok(bus.vfy_hdr)});
          end
        end
        if (bus.vfy_output_valid) begin
          ret_cnt++;
          ret_log.push_back(cyc);
        end
        if (acc_cnt - ret_cnt > max_out) max_out = acc_cnt - ret_cnt;
        if (bus.resp_valid) begin
          resp_cnt++;
          last_port = int'(bus.resp_port);
          last_ok = bus.resp_ok;
          if (exp_q.size() == 0) chk("resp_spurious", 1, 0);
          else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("resp_port", bus.resp_port, e.port);
            chk("resp_ok", bus.resp_ok, e.ok);
          end
        end
      end
    end
  end

  function automatic bit idle();
    bit q_empty;
    q_empty = 1;
    for (int p = 0; p < NP; p++) if (port_q[p].size() > 0) q_empty = 0;
    return q_empty && exp_q.size() == 0 && hdr_q.size() == 0 && vq.size() == 0;
  endfunction

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (idle()) break;
    end
    chk("idle_timeout", idle(), 1);
  endtask

  task automatic do_reset();
    for (int p = 0; p < NP; p++) port_q[p].delete();
    inj = 0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete(); hdr_q.delete(); vq.delete(); acyc_q.delete();
    grant_log.delete(); acc_log.delete(); ret_log.delete();
    acc_cnt = 0; ret_cnt = 0; max_out = 0;
    @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_vfy_req", bus.vfy_req, 0);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_resp_port", bus.resp_port, 0);
    chk("rst_err", err_unexpected, 0);
    @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    int r0;
    ipv4_hdr_t h;

    // Reset values
    do_reset();
    chk("rst_vfy_hdr", bus.vfy_hdr, 0);
    chk("rst_resp_ok", bus.resp_ok, 0);

    // Golden header alone on port 2
    r0 = resp_cnt;
    port_q[2].push_back(golden());
    wait_idle(100);
    chk("t1_resps", resp_cnt - r0, 1);
    chk("t1_port", last_port, 2);
    chk("t1_ok", last_ok, 1);
`ifdef IPV4_CHKSUM_ARB_STATS_EN
    @(negedge clk);
    chk("t1_stats_pass", stats_pass[2], 1);
    stats_clear = 1'b1;
    @(negedge clk);
    stats_clear = 1'b0;
    @(negedge clk);
    chk("t1_stats_clear", stats_pass[2], 0);
`endif

    // Corrupted checksum on port 0
    h = golden();
    h.hdr_chksum = 16'hb862;
    r0 = resp_cnt;
    port_q[0].push_back(h);
    wait_idle(100);
    chk("t2_resps", resp_cnt - r0, 1);
    chk("t2_port", last_port, 0);
    chk("t2_ok", last_ok, 0);

    // All ports requesting continuously: strict rotation from port 0
    do_reset();
    for (int k = 0; k < 8; k++)
      for (int p = 0; p < NP; p++)
        port_q[p].push_back(make_hdr(k * NP + p, (k % 3) != 0));
    wait_idle(400);
    chk("t3_grants", grant_log.size(), 32);
    for (int i = 0; i < grant_log.size(); i++) chk("t3_grant", grant_log[i], i % NP);

    // Slow verifier: credits cap outstanding work at MAX_INFLIGHT
    do_reset();
    lat = 10;
    port_q[0].push_back(make_hdr(100, 1));
    port_q[0].push_back(make_hdr(101, 0));
    port_q[1].push_back(make_hdr(102, 1));
    port_q[1].push_back(make_hdr(103, 1));
    port_q[2].push_back(make_hdr(104, 0));
    port_q[3].push_back(make_hdr(105, 1));
    wait_idle(400);
    chk("t4_accepts", acc_log.size(), 6);
    chk("t4_max_out", max_out, MI);
    if (acc_log.size() >= 5 && ret_log.size() >= 1) begin
      chk("t4_b2b", acc_log[3] - acc_log[0], 3);
      chk("t4_5th_after_ret", acc_log[4] > ret_log[0], 1);
    end

    // Result with nothing in flight
    do_reset();
    lat = 1;
    r0 = resp_cnt;
    @(negedge clk);
    inj = 1;
    repeat (6) @(negedge clk);
    chk("t5_no_resp", resp_cnt - r0, 0);
    chk("t5_err_set", err_unexpected, 1);
    repeat (4) @(negedge clk);
    chk("t5_err_sticky", err_unexpected, 1);
    do_reset();
    @(negedge clk);
    chk("t5_err_cleared", err_unexpected, 0);

    // Reset with three in flight, then full credit and port 0 first
    lat = 10;
    port_q[1].push_back(make_hdr(200, 1));
    port_q[2].push_back(make_hdr(201, 1));
    port_q[3].push_back(make_hdr(202, 1));
    for (int i = 0; i < 50 && acc_cnt < 3; i++) @(negedge clk);
    chk("t6_inflight3", acc_cnt, 3);
    r0 = resp_cnt;
    do_reset();
    chk("t6_no_resp", resp_cnt - r0, 0);
    for (int p = 0; p < NP; p++) port_q[p].push_back(make_hdr(300 + p, p != 1));
    wait_idle(400);
    chk("t6_accepts", acc_log.size(), 4);
    if (acc_log.size() >= 4) begin
      chk("t6_first_port", grant_log[0], 0);
      chk("t6_full_credit", acc_log[3] - acc_log[0], 3);
    end
    chk("t6_resps", resp_cnt - r0, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
